// File: rtl/pmcc_dpram_arbiter_pkg.sv
// Shared types and helpers for the PMC code RAM port-A arbiter.
package pmcc_dpram_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef enum logic {
      PMCC_M_SOC = 1'b0,
      PMCC_M_PMC = 1'b1
   } master_t;

   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic              rvalid;
      logic [DATA_W-1:0] rdata;
      logic              err;
   } mem_rsp_t;

   // Word access must be aligned and fall inside the RAM's byte range.
   function automatic logic access_bad(input logic [ADDR_W-1:0] addr, input int unsigned aw);
      return (addr[1:0] != 2'b00) || ((addr >> aw) != '0);
   endfunction

   // Read data is forced to zero for error responses and for the non-owning master.
   function automatic mem_rsp_t make_rsp(input logic hit, input logic err,
                                         input logic [DATA_W-1:0] rdata);
      mem_rsp_t r;
      r.rvalid = hit;
      r.err    = hit & err;
      r.rdata  = (hit & ~err) ? rdata : '0;
      return r;
   endfunction

endpackage

// File: rtl/pmcc_dpram_arbiter_if.sv
// OBI-style req/gnt/rvalid bus between one master and the PMC code RAM arbiter.
interface pmcc_dpram_arbiter_if;
   import pmcc_dpram_arb_pkg::*;

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (output req, addr, we, be, wdata,
                   input  gnt, rvalid, rdata, err);
   modport slave  (input  req, addr, we, be, wdata,
                   output gnt, rvalid, rdata, err);

endinterface

// File: rtl/pmcc_dpram_arbiter_arb2.sv
// Two-way grant logic: fixed m0 priority, or round-robin when
// PMCC_ARB_ROUND_ROBIN_EN is defined.
module pmcc_arb2
   import pmcc_dpram_arb_pkg::*;
(
`ifdef PMCC_ARB_ROUND_ROBIN_EN
   input  logic clk,
   input  logic rst,
`endif
   input  logic req0,
   input  logic req1,
   output logic gnt0_c,
   output logic gnt1_c
);

`ifdef PMCC_ARB_ROUND_ROBIN_EN
   master_t last_grant;

   // On contention the master not served most recently wins.
   always_comb begin
      gnt0_c = req0 && (!req1 || (last_grant == PMCC_M_PMC));
      gnt1_c = req1 && !gnt0_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         last_grant <= PMCC_M_PMC;
      else if (gnt0_c) last_grant <= PMCC_M_SOC;
      else if (gnt1_c) last_grant <= PMCC_M_PMC;
   end
`else
   assign gnt0_c = req0;
   assign gnt1_c = req1 && !req0;
`endif

endmodule

// File: rtl/pmcc_dpram_arbiter.sv
// Port-A arbiter for the PMC code dual-port RAM (SoC bus m0, PMC loader m1).
// Round-robin arbitration selected by PMCC_ARB_ROUND_ROBIN_EN.
module pmcc_dpram_arbiter
   import pmcc_dpram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   pmcc_dpram_arbiter_if.slave  m0,
   pmcc_dpram_arbiter_if.slave  m1,
   output logic                 ram_req,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic                 ram_we,
   output logic [BE_W-1:0]      ram_be,
   output logic [DATA_W-1:0]    ram_wdata,
   input  logic [DATA_W-1:0]    ram_rdata
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic     gnt0_c, gnt1_c, any_gnt_c, bad_c;
   master_t  owner_c;
   mem_req_t m0_req_c, m1_req_c, sel_c, ram_c;
   mem_rsp_t m0_rsp_c, m1_rsp_c;

   logic     rsp_valid, rsp_err;
   master_t  rsp_owner;

   pmcc_arb2 u_arb (
`ifdef PMCC_ARB_ROUND_ROBIN_EN
      .clk    (clk),
      .rst    (rst),
`endif
      .req0   (m0.req),
      .req1   (m1.req),
      .gnt0_c (gnt0_c),
      .gnt1_c (gnt1_c)
   );

   assign m0.gnt = gnt0_c;
   assign m1.gnt = gnt1_c;

   assign m0_req_c = '{req: m0.req, addr: m0.addr, we: m0.we, be: m0.be, wdata: m0.wdata};
   assign m1_req_c = '{req: m1.req, addr: m1.addr, we: m1.we, be: m1.be, wdata: m1.wdata};

   // Select the granted master; rejected accesses never reach the RAM.
   always_comb begin
      sel_c   = '0;
      owner_c = PMCC_M_SOC;
      if (gnt0_c) begin
         sel_c = m0_req_c;
      end else if (gnt1_c) begin
         sel_c   = m1_req_c;
         owner_c = PMCC_M_PMC;
      end
      any_gnt_c = gnt0_c | gnt1_c;
      bad_c     = any_gnt_c && access_bad(sel_c.addr, AW);
      ram_c     = '0;
      if (any_gnt_c && !bad_c) ram_c = sel_c;
   end

   assign ram_req   = ram_c.req;
   assign ram_addr  = ram_c.addr;
   assign ram_we    = ram_c.we;
   assign ram_be    = ram_c.be;
   assign ram_wdata = ram_c.wdata;

   // One-deep response pipeline, reloaded every cycle from the grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_owner <= PMCC_M_SOC;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= any_gnt_c;
         rsp_owner <= owner_c;
         rsp_err   <= bad_c;
      end
   end

   assign m0_rsp_c = make_rsp(rsp_valid && (rsp_owner == PMCC_M_SOC), rsp_err, ram_rdata);
   assign m1_rsp_c = make_rsp(rsp_valid && (rsp_owner == PMCC_M_PMC), rsp_err, ram_rdata);

   assign m0.rvalid = m0_rsp_c.rvalid;
   assign m0.rdata  = m0_rsp_c.rdata;
   assign m0.err    = m0_rsp_c.err;
   assign m1.rvalid = m1_rsp_c.rvalid;
   assign m1.rdata  = m1_rsp_c.rdata;
   assign m1.err    = m1_rsp_c.err;

endmodule

// File: tb/tb_pmcc_dpram_arbiter.sv
// Directed self-checking bench for pmcc_dpram_arbiter with a behavioural port-A RAM.
module tb_pmcc_dpram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ram_req, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [3:0]  ram_be;
   int          n_chk, n_fail;

   logic [31:0] mem [0:63];

   pmcc_dpram_arbiter_if m0_if ();
   pmcc_dpram_arbiter_if m1_if ();

   pmcc_dpram_arbiter #(.DEPTH(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .ram_req   (ram_req),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_be    (ram_be),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // Port-A model: registered read of pre-write contents, byte-masked write.
   initial for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
   always @(posedge clk) begin
      if (ram_req) begin
         ram_rdata <= mem[ram_addr[7:2]];
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.be = be; m0_if.wdata = wdata;
   endtask

   task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.be = be; m1_if.wdata = wdata;
   endtask

   task automatic idle();
      drive_m0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drive_m1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_chk++; if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m0_rvalid: got %b exp 0", m0_if.rvalid); end
      n_chk++; if (m1_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m1_rvalid: got %b exp 0", m1_if.rvalid); end
      n_chk++; if (m0_if.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m0_rdata: got %h exp 0", m0_if.rdata); end
      n_chk++; if (m0_if.err !== 1'b0) begin n_fail++; $display("FAIL rst_m0_err: got %b exp 0", m0_if.err); end
      n_chk++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL rst_ram_req: got %b exp 0", ram_req); end
      n_chk++; if (m0_if.gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m0_gnt: got %b exp 0", m0_if.gnt); end
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (m0_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rel_m0_rvalid: got %b exp 0", m0_if.rvalid); end
   endtask

   task automatic test_write_read();
      @(negedge clk); drive_m0(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
      #1;
      n_chk++; if (m0_if.gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b exp 1", m0_if.gnt); end
      n_chk++; if ({ram_req, ram_we} !== 2'b11) begin n_fail++; $display("FAIL wr_ram_req_we: got %b exp 11", {ram_req, ram_we}); end
      n_chk++; if (ram_addr !== 32'h10 || ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_ram_fwd: got %h/%h exp 10/deadbeef", ram_addr, ram_wdata); end
      @(negedge clk);
      n_chk++; if ({m0_if.rvalid, m0_if.err} !== 2'b10) begin n_fail++; $display("FAIL wr_rsp: got %b exp 10", {m0_if.rvalid, m0_if.err}); end
      drive_m0(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      #1;
      n_chk++; if (m0_if.gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b exp 1", m0_if.gnt); end
      @(negedge clk);
      n_chk++; if (m0_if.rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b exp 1", m0_if.rvalid); end
      n_chk++; if (m0_if.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h exp deadbeef", m0_if.rdata); end
      idle();
   endtask

   task automatic test_byte_write();
      @(negedge clk); drive_m1(1'b1, 1'b1, 32'h10, 4'b0010, 32'h0000AA00);
      #1;
      n_chk++; if ({m0_if.gnt, m1_if.gnt} !== 2'b01) begin n_fail++; $display("FAIL bw_gnt: got %b exp 01", {m0_if.gnt, m1_if.gnt}); end
      @(negedge clk);
      n_chk++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b01) begin n_fail++; $display("FAIL bw_rvalid: got %b exp 01", {m0_if.rvalid, m1_if.rvalid}); end
      idle(); drive_m0(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      @(negedge clk);
      n_chk++; if (m0_if.rdata !== 32'hDEADAAEF) begin n_fail++; $display("FAIL bw_rdata: got %h exp deadaaef", m0_if.rdata); end
      idle();
   endtask

   task automatic test_error();
      @(negedge clk); drive_m0(1'b1, 1'b0, 32'h13, 4'hF, 32'h0);
      #1;
      n_chk++; if ({m0_if.gnt, ram_req} !== 2'b10) begin n_fail++; $display("FAIL mis_gnt_req: got %b exp 10", {m0_if.gnt, ram_req}); end
      @(negedge clk);
      n_chk++; if ({m0_if.rvalid, m0_if.err} !== 2'b11) begin n_fail++; $display("FAIL mis_rsp: got %b exp 11", {m0_if.rvalid, m0_if.err}); end
      n_chk++; if (m0_if.rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h exp 0", m0_if.rdata); end
      drive_m0(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
      #1;
      n_chk++; if ({m0_if.gnt, ram_req} !== 2'b10) begin n_fail++; $display("FAIL oor_gnt_req: got %b exp 10", {m0_if.gnt, ram_req}); end
      @(negedge clk);
      n_chk++; if ({m0_if.rvalid, m0_if.err} !== 2'b11 || m0_if.rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rsp: got %b/%h exp 11/0", {m0_if.rvalid, m0_if.err}, m0_if.rdata); end
      drive_m0(1'b1, 1'b1, 32'h12, 4'hF, 32'hFFFFFFFF);
      @(negedge clk);
      n_chk++; if (m0_if.err !== 1'b1) begin n_fail++; $display("FAIL mis_wr_err: got %b exp 1", m0_if.err); end
      drive_m0(1'b1, 1'b1, 32'h104, 4'hF, 32'hFFFFFFFF);
      @(negedge clk);
      n_chk++; if (m0_if.err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b exp 1", m0_if.err); end
      drive_m0(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      @(negedge clk);
      n_chk++; if (m0_if.rdata !== 32'hDEADAAEF || m0_if.err !== 1'b0) begin n_fail++; $display("FAIL err_ram_intact: got %h/%b exp deadaaef/0", m0_if.rdata, m0_if.err); end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d;
      @(negedge clk); drive_m1(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (m1_if.gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b exp 1", i, m1_if.gnt); end
         @(negedge clk);
         exp_d = 32'h1000_0000 + 32'(i);
         n_chk++; if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== exp_d) begin n_fail++; $display("FAIL b2b_rsp%0d: got %b/%h exp 1/%h", i, m1_if.rvalid, m1_if.rdata, exp_d); end
         if (i < 2) drive_m1(1'b1, 1'b0, 32'(4 * (i + 1)), 4'hF, 32'h0);
         else       idle();
      end
   endtask

   task automatic test_contention();
      logic exp_m1;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      drive_m0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      drive_m1(1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
      for (int k = 0; k < 4; k++) begin
`ifdef PMCC_ARB_ROUND_ROBIN_EN
         exp_m1 = (k % 2) == 1;
`else
         exp_m1 = 1'b0;
`endif
         #1;
         n_chk++; if ({m0_if.gnt, m1_if.gnt} !== {~exp_m1, exp_m1}) begin n_fail++; $display("FAIL con_gnt%0d: got %b exp %b", k, {m0_if.gnt, m1_if.gnt}, {~exp_m1, exp_m1}); end
         @(negedge clk);
         n_chk++; if ({m0_if.rvalid, m1_if.rvalid} !== {~exp_m1, exp_m1}) begin n_fail++; $display("FAIL con_rvalid%0d: got %b exp %b", k, {m0_if.rvalid, m1_if.rvalid}, {~exp_m1, exp_m1}); end
         if (exp_m1) begin
            n_chk++; if (m1_if.rdata !== 32'h1000_0002) begin n_fail++; $display("FAIL con_m1_rdata%0d: got %h exp 10000002", k, m1_if.rdata); end
         end else begin
            n_chk++; if (m0_if.rdata !== 32'h1000_0000) begin n_fail++; $display("FAIL con_m0_rdata%0d: got %h exp 10000000", k, m0_if.rdata); end
         end
      end
      idle();
   endtask

   task automatic test_reset_mid();
      @(negedge clk); drive_m0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      #1;
      n_chk++; if (m0_if.gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b exp 1", m0_if.gnt); end
      #1; rst = 1'b1; idle();
      @(negedge clk);
      n_chk++; if ({m0_if.rvalid, m1_if.rvalid, m0_if.err} !== 3'b000) begin n_fail++; $display("FAIL rm_rvalid: got %b exp 000", {m0_if.rvalid, m1_if.rvalid, m0_if.err}); end
      n_chk++; if (m0_if.rdata !== 32'h0 || ram_req !== 1'b0 || m0_if.gnt !== 1'b0) begin n_fail++; $display("FAIL rm_outs: got %h/%b/%b exp 0/0/0", m0_if.rdata, ram_req, m0_if.gnt); end
      drive_m1(1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
      @(negedge clk); rst = 1'b0;
      #1;
      n_chk++; if (m1_if.gnt !== 1'b1) begin n_fail++; $display("FAIL rm_held_gnt: got %b exp 1", m1_if.gnt); end
      @(negedge clk);
      n_chk++; if ({m0_if.rvalid, m1_if.rvalid} !== 2'b01 || m1_if.rdata !== 32'h1000_0002) begin n_fail++; $display("FAIL rm_held_rsp: got %b/%h exp 01/10000002", {m0_if.rvalid, m1_if.rvalid}, m1_if.rdata); end
      idle();
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      test_reset();
      test_write_read();
      test_byte_write();
      test_error();
      test_back_to_back();
      test_contention();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
